// File: rtl/lifo_reader.sv
// lifo_reader: pops a commanded number of words from a LIFO-style stack
// (rn/empty/stk_data), absorbs the stack read latency with a delay line of
// valid bits, and presents the words on a valid/ready stream through a
// credit-managed buffer.
//
// Handshake: a word moves on the output stream at a rising clk edge where
// m_valid && m_ready. m_valid and m_data come from flops only; m_valid never
// drops and m_data never changes while m_valid && !m_ready.
//
// Optional feature macro: LIFO_RD_LAST_EN adds m_last, flagging the final
// word of each command.
module lifo_reader #(
  parameter int WIDTH  = 8,
  parameter int CW     = 8,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             rn,
  input  logic             empty,
  input  logic [WIDTH-1:0] stk_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef LIFO_RD_LAST_EN
  output logic             m_last,
`endif
  output logic [1:0]       dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic             count_mode_q, count_mode_d;
  logic             err_q, err_d;
  logic [OW-1:0]    outs_q, outs_d;
  logic [RD_LAT-1:0] lat_q, lat_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;

  logic             rn_int;
  logic             done_int;
  logic             push_in;
  logic             pop_out;
  logic             words_left;
  logic             has_credit;
  logic [OW:0]      credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pop request: stack has data, command wants more, and the words already
  // owed to the buffer (in flight + stored, minus the one leaving now) leave room.
  always_comb begin
    pop_out     = (occ_q != '0) && m_ready;
    push_in     = lat_q[RD_LAT-1];
    credit_used = {1'b0, outs_q} + {1'b0, occ_q} - (OW + 1)'(pop_out);
    has_credit  = credit_used < (OW + 1)'(DEPTH);
    words_left  = !count_mode_q || (remaining_q != '0);
    rn_int      = (state_q == S_POP) && !empty && words_left && has_credit;
  end

  // Command FSM: next state, remaining counter, underflow flag, done pulse.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    count_mode_d = count_mode_q;
    err_d        = err_q;
    done_int     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d  = count;
          count_mode_d = (count != '0);
          err_d        = 1'b0;
          state_d      = S_POP;
        end
      end
      S_POP: begin
        if (rn_int) begin
          if (count_mode_q) begin
            remaining_d = remaining_q - CW'(1);
            if (remaining_q == CW'(1)) state_d = S_DRAIN;
          end
        end else if (empty) begin
          state_d = S_DRAIN;
          if (count_mode_q && (remaining_q != '0)) err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((outs_q == '0) && (occ_q == '0)) begin
          done_int = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-return tracking and output buffer bookkeeping.
  always_comb begin
    outs_d = outs_q;
    if (rn_int && !push_in)      outs_d = outs_q + OW'(1);
    else if (!rn_int && push_in) outs_d = outs_q - OW'(1);

    lat_d    = lat_q;
    lat_d[0] = rn_int;
    for (int i = 1; i < RD_LAT; i++) lat_d[i] = lat_q[i-1];

    occ_d = occ_q;
    if (push_in && !pop_out)      occ_d = occ_q + OW'(1);
    else if (!push_in && pop_out) occ_d = occ_q - OW'(1);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_in) begin
      mem_d[wr_ptr_q] = stk_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_out) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // State and datapath registers; reset discards every in-flight and buffered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      count_mode_q <= 1'b0;
      err_q        <= 1'b0;
      outs_q       <= '0;
      lat_q        <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      count_mode_q <= count_mode_d;
      err_q        <= err_d;
      outs_q       <= outs_d;
      lat_q        <= lat_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

`ifdef LIFO_RD_LAST_EN
  logic [DEPTH-1:0] last_q, last_d;
  logic             stop_pops;

  // A returning word is the last one when no further pop can be issued and it
  // is the only word still in flight.
  always_comb begin
    stop_pops = (state_q == S_DRAIN) || ((state_q == S_POP) && !rn_int && empty);
    last_d    = last_q;
    if (push_in) last_d[wr_ptr_q] = stop_pops && (outs_q == OW'(1));
  end

  // Per-entry last flag, stored alongside the data word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= '0;
    else      last_q <= last_d;
  end

  assign m_last = (occ_q != '0) && last_q[rd_ptr_q];
`endif

  assign rn        = rn_int;
  assign m_valid   = (occ_q != '0);
  assign m_data    = mem_q[rd_ptr_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_int;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: behavioural stack with one-cycle read latency,
// scoreboard of expected output words, table of pop commands plus
// hand-written stall, underflow and reset sequences.
module tb_lifo_reader;
  localparam int WIDTH  = 8;
  localparam int CW     = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CW-1:0]    count;
  logic             rn;
  logic             empty;
  logic [WIDTH-1:0] stk_data = '0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       dbg_state;
`ifdef LIFO_RD_LAST_EN
  logic             m_last;
`endif

  lifo_reader #(.WIDTH(WIDTH), .CW(CW), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .rn(rn), .empty(empty),
    .stk_data(stk_data), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err),
`ifdef LIFO_RD_LAST_EN
    .m_last(m_last),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  int cyc = 0;
  int acc_cnt = 0;
  int acc_first = 0;
  int acc_last = 0;
  int rn_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stack model (read data one cycle after rn) ----------------
  logic [WIDTH-1:0] stk_mem [0:31];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign empty = (push_cnt == pop_cnt);

  initial forever begin
    @(posedge clk);
    if (rst === 1'b1 && rn === 1'b1 && push_cnt != pop_cnt) begin
      stk_data <= stk_mem[push_cnt - pop_cnt - 1];
      pop_cnt  <= pop_cnt + 1;
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] v);
    stk_mem[push_cnt - pop_cnt] = v;
    push_cnt++;
  endtask

  task automatic clear_stack();
    push_cnt = pop_cnt;
  endtask

  // ---------------- ready driver ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [WIDTH-1:0] e;
    logic             el;
    @(negedge clk);
    cyc++;
    if (rst === 1'b1) begin
      if (rn === 1'b1) begin
        rn_cnt++;
        check("rn_while_empty", empty, 0);
      end
      if (done === 1'b1) done_cnt++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (acc_cnt == 0) acc_first = cyc;
        acc_last = cyc;
        acc_cnt++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("m_data", m_data, e);
`ifdef LIFO_RD_LAST_EN
          check("m_last", m_last, el);
`else
          el = 1'b0;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [WIDTH-1:0] pre_vals [0:15];

  // Push the first n of pre_vals onto the stack and expect the top 'words' back.
  task automatic load_and_expect(input int n, input int words);
    for (int i = 0; i < n; i++) push_word(pre_vals[i]);
    for (int k = 0; k < words; k++) begin
      exp_q.push_back(pre_vals[n-1-k]);
      exp_last_q.push_back(k == words - 1);
    end
  endtask

  task automatic start_cmd(input int cnt);
    @(posedge clk); #1;
    start = 1'b1;
    count = CW'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  task automatic wait_done(input logic exp_err, input int budget);
    int k;
    int d0;
    d0 = done_cnt;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    check("err_at_done", err, exp_err);
    check("busy_with_done", busy, 1);
    check("all_words_out", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_falls", busy, 0);
    check("err_sticky", err, exp_err);
    check("done_pulse_count", done_cnt - d0, 1);
  endtask

  task automatic run_cmd(input int cnt, input logic exp_err);
    start_cmd(cnt);
    wait_done(exp_err, 300);
  endtask

  task automatic load_test_stack();
    pre_vals[0] = 8'd100; pre_vals[1] = 8'd150; pre_vals[2] = 8'd200;
    pre_vals[3] = 8'd40;  pre_vals[4] = 8'd70;  pre_vals[5] = 8'd65;
    pre_vals[6] = 8'd15;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int   n_pre;
    int   cnt;
    int   rmode;
    logic exp_err;
    int   exp_words;
  } vec_t;

  vec_t vecs [10];

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{3, 3, 0, 1'b0, 3};
    vecs[1] = '{5, 2, 1, 1'b0, 2};
    vecs[2] = '{4, 0, 1, 1'b0, 4};
    vecs[3] = '{2, 5, 2, 1'b1, 2};
    vecs[4] = '{6, 6, 1, 1'b0, 6};
    vecs[5] = '{0, 0, 0, 1'b0, 0};
    vecs[6] = '{0, 3, 0, 1'b1, 0};
    vecs[7] = '{8, 1, 2, 1'b0, 1};
    vecs[8] = '{10, 255, 1, 1'b1, 10};
    vecs[9] = '{9, 9, 2, 1'b0, 9};

    rst = 1'b0;
    start = 1'b0;
    count = '0;
    #23;
    check("rst_rn", rn, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
`ifdef LIFO_RD_LAST_EN
    check("rst_m_last", m_last, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    // Full pop, always ready: LIFO order, one word per cycle.
    load_test_stack();
    load_and_expect(7, 7);
    rdy_mode = 0;
    acc_cnt = 0;
    run_cmd(7, 1'b0);
    check("seq1_words", acc_cnt, 7);
    check("seq1_back_to_back", acc_last - acc_first, 6);
    check("seq1_stack_empty", empty, 1);

    // Count 3 with the consumer stalled for 10 cycles.
    clear_stack();
    load_and_expect(7, 3);
    rdy_mode = 3;
    rn_cnt = 0;
    start_cmd(3);
    repeat (10) begin
      @(negedge clk);
      if (m_valid === 1'b1) check("stall_hold_15", m_data, 15);
    end
    check("stall_valid", m_valid, 1);
    check("stall_rn_count3", rn_cnt, 3);
    rdy_mode = 0;
    wait_done(1'b0, 300);
    check("seq2_left_in_stack", push_cnt - pop_cnt, 4);

    // Count 0 with a stall: credit caps pops at DEPTH, then all 7 drain.
    clear_stack();
    load_and_expect(7, 7);
    rdy_mode = 3;
    rn_cnt = 0;
    start_cmd(0);
    repeat (10) @(negedge clk);
    check("credit_rn_bound", rn_cnt, DEPTH);
    check("credit_hold_15", m_data, 15);
    rdy_mode = 1;
    wait_done(1'b0, 300);
    check("seq3_stack_empty", empty, 1);

    // Underflow: 2 words, count 4.
    clear_stack();
    pre_vals[0] = 8'd5;
    pre_vals[1] = 8'd9;
    load_and_expect(2, 2);
    rdy_mode = 0;
    run_cmd(4, 1'b1);
    // err must clear on the next accepted start.
    pre_vals[0] = 8'd77;
    load_and_expect(1, 1);
    run_cmd(1, 1'b0);

    // Table of commands with random stack contents and ready patterns.
    for (int v = 0; v < 10; v++) begin
      clear_stack();
      for (int i = 0; i < vecs[v].n_pre; i++) pre_vals[i] = WIDTH'($urandom_range(0, 255));
      load_and_expect(vecs[v].n_pre, vecs[v].exp_words);
      rdy_mode = vecs[v].rmode;
      acc_cnt = 0;
      run_cmd(vecs[v].cnt, vecs[v].exp_err);
      check("vec_words", acc_cnt, vecs[v].exp_words);
      check("vec_left_in_stack", push_cnt - pop_cnt, vecs[v].n_pre - vecs[v].exp_words);
    end

    // Reset with two words buffered and one in flight.
    clear_stack();
    for (int i = 1; i <= 7; i++) push_word(WIDTH'(i));
    rdy_mode = 3;
    @(posedge clk); #1;
    start = 1'b1;
    count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_rn", rn, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_stack();
    pre_vals[0] = 8'd11;
    pre_vals[1] = 8'd22;
    pre_vals[2] = 8'd33;
    load_and_expect(3, 1);
    rdy_mode = 0;
    acc_cnt = 0;
    run_cmd(1, 1'b0);
    check("post_rst_words", acc_cnt, 1);
    check("post_rst_left", push_cnt - pop_cnt, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
